// File: rtl/rv_pkg.sv
// Shared definitions for the single-issue RISC-V core: default datapath
// widths, the canonical NOP encoding, major opcode values and the fetch
// stage run/done state type.
package rv_pkg;

  localparam int unsigned BITSIZE_DEF = 32;
  localparam int unsigned REGSIZE_DEF = 32;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory address/data pair plus the IF/ID
// pipeline register contents handed to decode.
//   master : fetch stage (drives imem_addr and if_id_*, reads imem_data)
//   slave  : memory/decode side (drives imem_data, reads the rest)
interface instruction_fetch_if #(
  parameter int unsigned BITSIZE = 32,
  parameter int unsigned REGSIZE = 32
);
  logic [REGSIZE-1:0] imem_addr;
  logic [BITSIZE-1:0] imem_data;
  logic [BITSIZE-1:0] if_id_instr;
  logic [REGSIZE-1:0] if_id_pc;
  logic               if_id_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid
  );
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   load            : capture instr_in/pc_in, mark valid
//   bubble          : insert NOP, clear valid, keep pc (wins over load)
//   instr_in, pc_in : fetched word and its word index
//   instr, pc, valid: registered outputs to decode
// With neither load nor bubble the register holds.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int unsigned BITSIZE = BITSIZE_DEF,
  parameter int unsigned REGSIZE = REGSIZE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [BITSIZE-1:0] instr_in,
  input  logic [REGSIZE-1:0] pc_in,
  output logic [BITSIZE-1:0] instr,
  output logic [REGSIZE-1:0] pc,
  output logic               valid
);

  localparam logic [BITSIZE-1:0] NOP_W = BITSIZE'(NOP);

  logic [BITSIZE-1:0] instr_d, instr_q;
  logic [REGSIZE-1:0] pc_d, pc_q;
  logic               valid_d, valid_q;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_W;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_W;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage. Holds the word-indexed PC, presents it to the
// asynchronous-read instruction memory and captures the returned word into
// the IF/ID register. Handles decode stall, taken-branch redirect (one
// bubble) and halts once the PC leaves 0..MEM_DEPTH-1.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   stall          : decode cannot accept; hold PC, IF/ID and count
//   branch_taken   : redirect request from execute (overrides stall)
//   branch_target  : word index fetched next on redirect
//   bus (master)   : imem_addr/imem_data and if_id_instr/pc/valid
//   fetch_done     : PC out of range, fetch halted
//   fetch_count    : number of valid instructions delivered (wraps)
module instruction_fetch
  import rv_pkg::*;
#(
  parameter int unsigned BITSIZE   = BITSIZE_DEF,
  parameter int unsigned REGSIZE   = REGSIZE_DEF,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned RESET_PC  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [REGSIZE-1:0]  branch_target,
  instruction_fetch_if.master bus,
  output logic                fetch_done,
  output logic [31:0]         fetch_count
);

  localparam logic [REGSIZE-1:0] DEPTH_W    = REGSIZE'(MEM_DEPTH);
  localparam logic [REGSIZE-1:0] RESET_PC_W = REGSIZE'(RESET_PC);

  fetch_state_t       state_d, state_q;
  logic [REGSIZE-1:0] pc_d, pc_q;
  logic [31:0]        count_d, count_q;
  logic               ld;
  logic               bub;

  logic [BITSIZE-1:0] if_instr;
  logic [REGSIZE-1:0] if_pc;
  logic               if_valid;

  // Priority: redirect > done > stall > advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    ld      = 1'b0;
    bub     = 1'b0;
    if (branch_taken) begin
      pc_d    = branch_target;
      bub     = 1'b1;
      state_d = (branch_target < DEPTH_W) ? RUN : DONE;
    end else if (state_q == DONE) begin
      bub = 1'b1;
    end else if (stall) begin
      // everything holds
    end else if (pc_q < DEPTH_W) begin
      ld      = 1'b1;
      pc_d    = pc_q + 1'b1;
      count_d = count_q + 32'd1;
    end else begin
      state_d = DONE;
      bub     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC_W;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg #(
    .BITSIZE (BITSIZE),
    .REGSIZE (REGSIZE)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .bubble   (bub),
    .instr_in (bus.imem_data),
    .pc_in    (pc_q),
    .instr    (if_instr),
    .pc       (if_pc),
    .valid    (if_valid)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = if_instr;
  assign bus.if_id_pc    = if_pc;
  assign bus.if_id_valid = if_valid;
  assign fetch_done      = (state_q == DONE);
  assign fetch_count     = count_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the single-issue RISC-V core. Holds the program counter, drives the word-indexed address of the asynchronous-read instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Supports a decode stall, a taken-branch redirect that squashes the in-flight fetch, and out-of-range PC detection.

## Interface
- `BITSIZE`, 32: instruction width.
- `REGSIZE`, 32: address / PC width.
- `MEM_DEPTH`, 32: number of instruction words; a valid PC is 0..MEM_DEPTH-1.
- `RESET_PC`, 1: word index of the first instruction.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `stall`  in  1: decode cannot accept; hold PC and IF/ID.
- `branch_taken`  in  1: redirect request from execute.
- `branch_target`  in  REGSIZE: word index to fetch next when `branch_taken`=1.
- `imem_addr`  out  REGSIZE: to instruction memory `Address`; equals `pc`.
- `imem_data`  in  BITSIZE: from instruction memory `ReadData1` (combinational).
- `if_id_instr`  out  BITSIZE: registered instruction.
- `if_id_pc`  out  REGSIZE: word index the instruction was fetched from.
- `if_id_valid`  out  1: `if_id_instr` is a real instruction.
- `fetch_done`  out  1: PC out of range; fetch halted.
- `fetch_count`  out  32: number of valid instructions delivered.

## Operation
- NOP constant: 32'h00000013 (ADDI x0,x0,0).
- Per rising edge, priority: redirect > done > stall > advance.
- Redirect (`branch_taken`=1, stall ignored): `pc`<=`branch_target`; `if_id_instr`<=NOP; `if_id_valid`<=0; `fetch_done`<=0 if target < MEM_DEPTH, else 1.
- Done (`fetch_done`=1, no redirect): PC and IF/ID frozen; `if_id_valid`<=0, `if_id_instr`<=NOP.
- Stall (`stall`=1): `pc`, `if_id_*`, `fetch_count` hold.
- Advance: if `pc` < MEM_DEPTH: `if_id_instr`<=`imem_data`, `if_id_pc`<=`pc`, `if_id_valid`<=1, `pc`<=`pc`+1, `fetch_count`+=1. If `pc` >= MEM_DEPTH: `fetch_done`<=1, `if_id_valid`<=0, `pc` held.
- PC arithmetic: modulo 2^REGSIZE; no wrap to 0 at MEM_DEPTH, detection above stops fetch instead.
- `fetch_count` counts edges where `if_id_valid` is loaded with 1; wraps at 2^32.
- States: RUN (`fetch_done`=0) and DONE (`fetch_done`=1); RUN->DONE on advance with out-of-range PC or redirect to out-of-range target; DONE->RUN only on in-range redirect or reset.

## Timing
- Reset (async, immediate): `pc`=RESET_PC, `if_id_instr`=NOP, `if_id_pc`=0, `if_id_valid`=0, `fetch_done`=0, `fetch_count`=0. `imem_addr`=RESET_PC during reset.
- `imem_addr` is combinationally `pc`; no other combinational path from inputs to outputs.
- Fetch latency: word at PC p appears on `if_id_instr` one edge after `imem_addr`=p.
- Redirect penalty: one bubble (`if_id_valid`=0 for one cycle), target instruction valid on the second edge after `branch_taken` sampled.
- Stall and redirect same edge: redirect wins, bubble inserted.
- Reset deasserted mid-stall: first edge after release obeys `stall` normally.

## Structure
- Shared package `rv_pkg`: NOP constant, opcode localparams (OP_IMM, LUI, OP, BRANCH, LOAD, STORE), BITSIZE/REGSIZE defaults.
- One sub-module: `if_id_reg` (instr, pc, valid with load/bubble/hold controls and async reset). PC, done flag and counter live in the top.

## Test plan
- Reset release, program at index 1 = 32'h00106093, index 2 = 32'h00001137, no stall -> edge 1: `if_id_instr`=32'h00106093, `if_id_pc`=1, valid=1; edge 2: 32'h00001137, `if_id_pc`=2; `fetch_count`=2.
- `stall`=1 for 3 cycles at `pc`=4 -> `imem_addr` stays 4, IF/ID and `fetch_count` unchanged, resumes with `if_id_pc`=4 after release.
- `branch_taken`=1, `branch_target`=7 with `pc`=6 -> next edge valid=0, instr=NOP, `pc`=7; following edge `if_id_pc`=7, valid=1.
- `branch_taken` and `stall` both 1 -> redirect taken, bubble inserted, `pc`=target.
- Run to `pc`=31 -> index 31 delivered, then `pc`=32 sets `fetch_done`=1, valid=0, count frozen; redirect to 1 clears `fetch_done`; redirect to 40 sets it.
- Assert `reset` asynchronously mid-cycle while valid=1 -> outputs return to reset values before next edge.
